// File: rtl/cpu_phase_gen.sv
// cpu_phase_gen: single-clock run/pause/step phase generator producing per-channel clock-enable strobes
module cpu_phase_gen #(
    parameter int NUM_CH = 2,
    parameter int CNT_W = 8,
    parameter int DEF_PERIOD = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              run,
    input  logic              step,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ch_en,
    output logic              step_done,
    output logic              running,
    output logic [31:0]       cycle_cnt
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, STEP = 2'd3;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_PERIOD);
    logic [1:0] state, nextState;
    logic stepPrev, stepEdge, active, wrHit;
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CNT_W-1:0] period [NUM_CH];
    logic [CNT_W-1:0] phase [NUM_CH];
    logic [CNT_W-1:0] shPeriod [NUM_CH];
    logic [CNT_W-1:0] shPhase [NUM_CH];
    logic [NUM_CH-1:0] pend, wrap;
    logic [CNT_W-1:0] wrPeriod, wrPhase;
    assign stepEdge = step & ~stepPrev;
    assign active = (state == RUN) || (state == STEP);
    assign wrPeriod = (cfg_period == '0) ? ONE : cfg_period;
    assign wrPhase = (cfg_phase >= wrPeriod) ? wrPeriod - ONE : cfg_phase;
    assign wrHit = cfg_we && (32'(cfg_ch) < NUM_CH);
    for (genvar i = 0; i < NUM_CH; i++) begin : gWrap
        assign wrap[i] = cnt[i] == period[i] - ONE;
    end
    // next state: clear beats run, run beats step; a step lasts one cycle then pauses
    always_comb
        nextState = clear ? IDLE :
                    (state == RUN) ? (run ? RUN : PAUSE) :
                    (state == STEP) ? PAUSE :
                    run ? RUN :
                    stepEdge ? STEP : state;
    // control state, step edge history and status outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            stepPrev <= 1'b1;
            running <= 1'b0;
            step_done <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state <= nextState;
            stepPrev <= step;
            running <= nextState == RUN;
            step_done <= !clear && state == STEP;
            cycle_cnt <= clear ? '0 : active ? cycle_cnt + 32'd1 : cycle_cnt;
        end
    end
    // per-channel counters, strobes and shadowed configuration taking effect on wrap
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ch_en <= '0;
            pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
                period[i] <= DEF;
                phase[i] <= '0;
                shPeriod[i] <= DEF;
                shPhase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_en[i] <= !clear && active && cnt[i] == phase[i];
                if (clear || (active && wrap[i])) begin
                    cnt[i] <= '0;
                    if (pend[i]) begin
                        period[i] <= shPeriod[i];
                        phase[i] <= shPhase[i];
                        pend[i] <= 1'b0;
                    end
                end else if (active) begin
                    cnt[i] <= cnt[i] + ONE;
                end
                if (wrHit && 32'(cfg_ch) == i) begin
                    if (clear || state == IDLE) begin
                        period[i] <= wrPeriod;
                        phase[i] <= wrPhase;
                    end else begin
                        shPeriod[i] <= wrPeriod;
                        shPhase[i] <= wrPhase;
                        pend[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_phase_gen.sv
// tb_cpu_phase_gen: directed stimulus with a cycle-level reference model and literal spot checks
module tb_cpu_phase_gen;
    logic Clk = 1'b0, Reset = 1'b1, run = 1'b0, step = 1'b0, clear = 1'b0, cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0] cfg_period = '0, cfg_phase = '0;
    logic [1:0] ch_en;
    logic step_done, running;
    logic [31:0] cycle_cnt;
    int total = 0, bad = 0;

    cpu_phase_gen dut (
        .Clk(Clk), .Reset(Reset), .run(run), .step(step), .clear(clear),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_phase(cfg_phase),
        .ch_en(ch_en), .step_done(step_done), .running(running), .cycle_cnt(cycle_cnt)
    );

    always #5 Clk = ~Clk;

    // reference model: position within period per channel, mode flags, pending config
    int mPer[2], mPh[2], mPos[2], sPer[2], sPh[2];
    bit mPend[2];
    bit mIdle, mRun, mStep, mPrev;
    bit [31:0] mCyc;
    logic [1:0] eEn;
    bit eDone, eRun;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            mPer[c] = 2; mPh[c] = 0; mPos[c] = 0; mPend[c] = 0;
        end
        mIdle = 1; mRun = 0; mStep = 0; mPrev = 1; mCyc = 0;
        eEn = '0; eDone = 0; eRun = 0;
    endtask

    task automatic modelStep();
        bit act, edgeS, nI, nR, nS;
        int p, f;
        act = mRun || mStep;
        edgeS = step && !mPrev;
        for (int c = 0; c < 2; c++) eEn[c] = !clear && act && mPos[c] == mPh[c];
        eDone = !clear && mStep;
        for (int c = 0; c < 2; c++) begin
            if (clear) mPos[c] = 0;
            else if (act) mPos[c] = (mPos[c] + 1) % mPer[c];
            if (mPend[c] && (clear || (act && mPos[c] == 0))) begin
                mPer[c] = sPer[c]; mPh[c] = sPh[c]; mPend[c] = 0;
            end
        end
        mCyc = clear ? 32'd0 : act ? mCyc + 32'd1 : mCyc;
        if (cfg_we && cfg_ch < 3'd2) begin
            p = (cfg_period == 8'd0) ? 1 : int'(cfg_period);
            f = (int'(cfg_phase) >= p) ? p - 1 : int'(cfg_phase);
            if (clear || mIdle) begin
                mPer[cfg_ch] = p; mPh[cfg_ch] = f;
            end else begin
                sPer[cfg_ch] = p; sPh[cfg_ch] = f; mPend[cfg_ch] = 1;
            end
        end
        if (clear) {nI, nR, nS} = 3'b100;
        else if (mRun) {nI, nR, nS} = {1'b0, run, 1'b0};
        else if (mStep) {nI, nR, nS} = 3'b000;
        else if (run) {nI, nR, nS} = 3'b010;
        else if (edgeS) {nI, nR, nS} = 3'b001;
        else {nI, nR, nS} = {mIdle, 2'b00};
        mIdle = nI; mRun = nR; mStep = nS; eRun = nR;
        mPrev = step;
    endtask

    // advance the model on each edge and compare every output shortly after
    always @(posedge Clk) begin
        if (Reset) modelReset();
        else modelStep();
        #1;
        check("ch_en", 32'(ch_en), 32'(eEn));
        check("step_done", 32'(step_done), 32'(eDone));
        check("running", 32'(running), 32'(eRun));
        check("cycle_cnt", cycle_cnt, mCyc);
    end

    task automatic tick(int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic cfg(int ch, int per, int ph);
        cfg_we = 1; cfg_ch = 3'(ch); cfg_period = 8'(per); cfg_phase = 8'(ph);
        tick(1);
        cfg_we = 0;
    endtask

    logic [1:0] exp6 [4] = '{2'b01, 2'b01, 2'b01, 2'b11};
    int sd;

    initial begin
        modelReset();
        tick(2);
        check("rst_en", 32'(ch_en), 0);
        check("rst_run", 32'(running), 0);
        check("rst_cyc", cycle_cnt, 0);
        Reset = 0;
        // defaults: both channels period 2 phase 0
        run = 1;
        tick(1); check("lat_run", 32'(running), 1); check("lat_en", 32'(ch_en), 0);
        tick(1); check("first_en", 32'(ch_en), 3);
        tick(1); check("alt_en", 32'(ch_en), 0);
        tick(4); check("cyc6", cycle_cnt, 6);
        clear = 1; run = 0;
        tick(1); clear = 0;
        check("clr_cyc", cycle_cnt, 0); check("clr_en", 32'(ch_en), 0);
        // idle write: ch1 period 4 phase 3
        cfg(1, 4, 3);
        run = 1;
        tick(1);
        tick(3); check("p4_j3", 32'(ch_en), 1);
        tick(1); check("p4_j4", 32'(ch_en), 2);
        tick(4); check("p4_j8", 32'(ch_en), 2);
        // running write to ch0 while its count is 0: takes effect at wrap
        cfg(0, 3, 0); check("sh_a", 32'(ch_en[0]), 1);
        tick(2); check("sh_b", 32'(ch_en[0]), 1);
        tick(2); check("sh_c", 32'(ch_en[0]), 0);
        tick(1); check("sh_d", 32'(ch_en[0]), 1);
        // run 3, pause 5, resume
        clear = 1; run = 0;
        tick(1); clear = 0; run = 1;
        tick(3); run = 0;
        tick(1); check("pz_cyc3", cycle_cnt, 3);
        tick(1); check("pz_en", 32'(ch_en), 0); check("pz_run", 32'(running), 0);
        tick(3); check("pz_hold", cycle_cnt, 3);
        run = 1;
        tick(1); check("rs_en0", 32'(ch_en), 0); check("rs_run", 32'(running), 1);
        tick(1); check("rs_en", 32'(ch_en), 3); check("rs_cyc", cycle_cnt, 4);
        // single step with step held for 4 cycles
        run = 0;
        tick(1); check("st_cyc0", cycle_cnt, 5);
        step = 1; sd = 0;
        repeat (4) begin tick(1); sd += int'(step_done); end
        step = 0;
        check("st_pulses", sd, 1); check("st_cyc", cycle_cnt, 6);
        tick(1);
        step = 1; run = 1;
        tick(1); check("sr_run", 32'(running), 1);
        tick(1); check("sr_done", 32'(step_done), 0); check("sr_cyc", cycle_cnt, 7);
        run = 0; step = 0;
        tick(1);
        // boundary writes: period 0, phase clamp, out-of-range channel
        clear = 1;
        tick(1); clear = 0;
        cfg(0, 0, 5);
        cfg(1, 5, 1);
        cfg(1, 4, 9);
        cfg(5, 7, 0);
        run = 1;
        tick(1);
        for (int j = 0; j < 4; j++) begin
            tick(1); check("bnd_en", 32'(ch_en), 32'(exp6[j]));
        end
        // asynchronous reset mid-run with step held through it
        tick(1);
        #2 Reset = 1; step = 1;
        #1;
        check("arst_en", 32'(ch_en), 0);
        check("arst_run", 32'(running), 0);
        check("arst_cyc", cycle_cnt, 0);
        modelReset();
        tick(1); Reset = 0; run = 0;
        tick(2);
        check("hold_run", 32'(running), 0);
        check("hold_done", 32'(step_done), 0);
        check("hold_cyc", cycle_cnt, 0);
        step = 0;
        tick(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_phase_gen.md
Name: cpu_phase_gen

Overview:
- Single-clock, parametrised phase/strobe generator for the CPU.
- Produces NUM_CH independent clock-enable strobes from Clk. Each channel has a programmable period and phase. This replaces the free-running multi-clock (Clk/pcCLK) scheme with enables in one clock domain.
- Supports run, pause, single-step and clear, so the CPU datapath and PC stage can be advanced deterministically.
- Sits between the top-level clock/reset and the cpu core's stage enables.

Parameters:
NUM_CH, 2, number of strobe channels (1..8)
CNT_W, 8, width of the per-channel period/phase counters
DEF_PERIOD, 2, reset period of every channel (1..2^CNT_W-1)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
run  input  1  level: 1 = free-run, 0 = pause
step  input  1  single-step request, rising-edge detected internally
clear  input  1  synchronous clear to IDLE, counters to 0
cfg_we  input  1  configuration write strobe
cfg_ch  input  3  channel index for write
cfg_period  input  CNT_W  new period (count length)
cfg_phase  input  CNT_W  new phase (strobe position within period)
ch_en  output  NUM_CH  registered one-cycle enable strobes
step_done  output  1  one-cycle pulse after a step completes
running  output  1  1 while state is RUN
cycle_cnt  output  32  count of active (RUN or STEP) cycles

Behaviour:
- Reset (async, Reset=1):
  - State IDLE; all counters 0; period = DEF_PERIOD; phase = 0; no pending configuration.
  - ch_en=0, step_done=0, running=0, cycle_cnt=0.
  - Step edge detector history is set to 1, so a step held high through reset does not fire.
- FSM states: IDLE, RUN, PAUSE, STEP.
- Priority at each edge: Reset > clear > run > step.
- clear=1 in any state:
  - Next state IDLE; counters 0; cycle_cnt 0; ch_en 0 next cycle.
  - Pending configuration is applied immediately.
- IDLE:
  - run=1 -> RUN; counters remain 0.
  - step edge -> STEP.
- RUN:
  - run=0 -> PAUSE. Counters hold their current values.
  - run=1 stays in RUN.
- PAUSE:
  - run=1 -> RUN, resuming from the held counter values (no restart).
  - step edge -> STEP.
- STEP: lasts exactly one cycle, then PAUSE. step_done=1 in the cycle after STEP.
- Step while in RUN, or on the same edge as run=1: ignored. Step edge = step & ~step_prev.
- Active cycle = state RUN or STEP. Each active cycle, every channel counter does cnt <= (cnt==period-1) ? 0 : cnt+1.
- Strobe timing:
  - ch_en[i] is registered. It is high for the cycle following an active cycle in which cnt[i]==phase[i].
  - ch_en is 0 after any non-active cycle.
  - Latency: run sampled at edge k -> RUN at k. A phase-0 channel strobes in the cycle starting at edge k+1.
- period=1: counter stays 0 and the channel strobes on every active cycle.
- Configuration writes (cfg_we=1):
  - cfg_ch>=NUM_CH is ignored.
  - cfg_period=0 is stored as 1.
  - cfg_phase>=stored period is stored as period-1.
  - In IDLE: applied on the next edge.
  - In RUN/PAUSE/STEP: held in a per-channel shadow and applied on the edge where that channel's counter wraps to 0. A later write before the wrap overwrites the shadow.
- cycle_cnt: +1 per active cycle; wraps from 2^32-1 to 0.
- running = (state==RUN), registered, 0 at reset.

Test Plan:
- Reset then run=1, defaults (DEF_PERIOD=2, phase 0) -> ch_en[0] and ch_en[1] high on alternating cycles starting at edge 2 after run; cycle_cnt=6 after 6 RUN cycles.
- In IDLE write ch1 period=4, phase=3, then run -> ch_en[1] high once every 4 cycles, first at the 4th active cycle's following cycle; ch0 is unaffected.
- In RUN, write ch0 period=3 while ch0 cnt=0 -> old period=2 continues until the wrap, then period 3 takes effect.
- Sequence run=1 for 3 cycles, run=0 for 5 cycles, run=1 -> no strobes and cycle_cnt frozen during the 5 cycles; counters resume from the held values.
- From PAUSE, step held high for 4 cycles -> exactly one active cycle, one step_done pulse, cycle_cnt+1. A step asserted together with run=1 is ignored.
- Error and boundary cases:
  - Write period=0 -> period 1, strobe every cycle.
  - Write phase=9 with period=4 -> phase 3.
  - cfg_ch=5 with NUM_CH=2 -> no change.
  - Reset asserted mid-RUN -> all outputs 0 immediately (async); state IDLE.
